pwm_adc: RTL and testbench

//  Receive-side counterpart of the PWM DAC: recovers the sample code from a
//  PWM bitstream, one code per window of CYCLES_PER_WINDOW cycles.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_adc_if.sv | 21 ++
 rtl/pwm_window_counter.sv | 39 +++
 rtl/pwm_adc.sv | 112 +++++++++++
 tb/tb_pwm_adc.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM DAC/ADC pair: default window length,
// receiver FSM states and the high-count to code mapping.
package pwm_pkg;

    localparam int DEFAULT_CYCLES_PER_WINDOW = 1024;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // The DAC drives c+1 high cycles for c>0 and none for c=0, so a single
    // high cycle cannot come from a good DAC and folds onto code 0.
    function automatic int hi_to_code(input int h);
        return (h == 0) ? 0 : h - 1;
    endfunction

endpackage

// File: rtl/pwm_adc_if.sv
// Recovered-code stream: the ADC sources codes, the consumer accepts them
// with a valid/ready handshake.
interface pwm_adc_if #(
    parameter int CODE_WIDTH = 10
);
    logic [CODE_WIDTH-1:0] code;
    logic                  code_valid;
    logic                  code_ready;

    modport master (
        output code,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/pwm_window_counter.sv
// Bit position and high-cycle accumulator for one PWM window, plus
// detection of the window's last bit and of a sync arriving before it.
module pwm_window_counter #(
    parameter int N  = 1024,
    parameter int CW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pwm,
    input  logic        sync_in,
    output logic        last_bit,
    output logic        early_sync,
    output logic [CW:0] hi_total
);

    logic [CW-1:0] idx_reg;
    logic [CW:0]   hi_reg;

    assign last_bit   = (idx_reg == CW'(N - 1));
    assign early_sync = sync_in && !last_bit;

    // Count including the bit being sampled this cycle; on the last bit this
    // is the full window total and may reach N, hence the extra bit.
    assign hi_total = hi_reg + (CW + 1)'(pwm);

    // Held at zero while unlocked so the first bit after the locking sync
    // lands at index 0; any sync or window end realigns.
    always_ff @(posedge clk) begin
        if (rst || !en || sync_in || last_bit) begin
            idx_reg <= '0;
            hi_reg  <= '0;
        end else begin
            idx_reg <= idx_reg + 1'b1;
            hi_reg  <= hi_total;
        end
    end

endmodule

// File: rtl/pwm_adc.sv
// PWM receiver: locks to the DAC's window sync, recovers one code per window
// and presents it on a valid/ready stream with sticky error flags.
module pwm_adc
    import pwm_pkg::*;
#(
    parameter int CYCLES_PER_WINDOW = DEFAULT_CYCLES_PER_WINDOW,
    parameter int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      pwm,
    input  logic      sync_in,
    output logic      locked,
    output logic      sync_err,
    output logic      overrun,
    input  logic      clr_err,
    pwm_adc_if.master smp
);

    state_t                state_reg;
    logic [CODE_WIDTH-1:0] code_reg;
    logic                  valid_reg;
    logic                  locked_reg;
    logic                  sync_err_reg;
    logic                  overrun_reg;

    logic                  last_bit;
    logic                  early_sync;
    logic [CODE_WIDTH:0]   hi_total;

    logic                  is_locked;
    logic                  publish;
    logic                  sync_fault;
    logic                  overwrite;
    logic [CODE_WIDTH-1:0] new_code;

    pwm_window_counter #(
        .N  (CYCLES_PER_WINDOW),
        .CW (CODE_WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (is_locked),
        .pwm        (pwm),
        .sync_in    (sync_in),
        .last_bit   (last_bit),
        .early_sync (early_sync),
        .hi_total   (hi_total)
    );

    assign is_locked  = (state_reg == LOCKED);
    // A missing sync still publishes: the window length is trusted over sync.
    assign publish    = is_locked && last_bit;
    assign sync_fault = is_locked && ((last_bit && !sync_in) || early_sync);
    assign overwrite  = publish && valid_reg && !smp.code_ready;
    assign new_code   = CODE_WIDTH'(hi_to_code(int'(hi_total)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= UNLOCKED;
            locked_reg   <= 1'b0;
            code_reg     <= '0;
            valid_reg    <= 1'b0;
            sync_err_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            case (state_reg)
                UNLOCKED: begin
                    if (sync_in) begin
                        state_reg  <= LOCKED;
                        locked_reg <= 1'b1;
                    end
                end
                LOCKED: begin
                    state_reg  <= LOCKED;
                    locked_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= UNLOCKED;
                    locked_reg <= 1'b0;
                end
            endcase

            if (publish) begin
                code_reg  <= new_code;
                valid_reg <= 1'b1;
            end else if (valid_reg && smp.code_ready) begin
                valid_reg <= 1'b0;
            end

            // Setting wins over a simultaneous clear so no event is lost.
            if (sync_fault) begin
                sync_err_reg <= 1'b1;
            end else if (clr_err) begin
                sync_err_reg <= 1'b0;
            end

            if (overwrite) begin
                overrun_reg <= 1'b1;
            end else if (clr_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign smp.code       = code_reg;
    assign smp.code_valid = valid_reg;
    assign locked         = locked_reg;
    assign sync_err       = sync_err_reg;
    assign overrun        = overrun_reg;

endmodule

// File: tb/tb_pwm_adc.sv
// Bench for pwm_adc with an 8-cycle window: a DAC-style window driver feeds
// pwm/sync_in, a scoreboard queue holds expected codes for the monitor.
module tb_pwm_adc;

    localparam int N  = 8;
    localparam int CW = 3;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic pwm      = 1'b0;
    logic sync_in  = 1'b0;
    logic clr_err  = 1'b0;
    logic locked;
    logic sync_err;
    logic overrun;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    pwm_adc_if #(.CODE_WIDTH(CW)) smp();

    pwm_adc #(
        .CYCLES_PER_WINDOW (N),
        .CODE_WIDTH        (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm      (pwm),
        .sync_in  (sync_in),
        .locked   (locked),
        .sync_err (sync_err),
        .overrun  (overrun),
        .clr_err  (clr_err),
        .smp      (smp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: every accepted code must match the oldest expected code.
    always @(negedge clk) begin
        if (smp.code_valid && smp.code_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL code: got unexpected %0d, want no code", smp.code);
            end else begin
                check("code", int'(smp.code), exp_q.pop_front());
            end
        end
    end

    // Inputs change 1 time unit after an edge and are sampled on the next.
    task automatic drive_bit(input logic p, input logic s);
        pwm     = p;
        sync_in = s;
        @(posedge clk);
        #1;
    endtask

    function automatic int dac_highs(input int c);
        return (c == 0) ? 0 : c + 1;
    endfunction

    // Drive window bits first..N-1: pwm high for bits below highs, sync on
    // the last bit if requested; optionally expect a code one cycle later.
    task automatic win(input int first, input int highs, input bit sync_last,
                       input bit push, input int exp_code);
        for (int i = first; i < N; i++) begin
            if (i == N - 1 && push) exp_q.push_back(exp_code);
            drive_bit(logic'(i < highs), logic'(sync_last && i == N - 1));
        end
        if (push) check("valid_latency", int'(smp.code_valid), 1);
    endtask

    int t1_dac[6] = '{0, 0, 7, 7, 3, 3};
    int t1_exp[6] = '{0, 0, 7, 7, 3, 3};

    initial begin
        smp.code_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", int'(locked), 0);
        check("rst_valid", int'(smp.code_valid), 0);
        check("rst_code", int'(smp.code), 0);
        check("rst_sync_err", int'(sync_err), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        // Unlocked: pwm ignored until the first sync.
        repeat (5) drive_bit(1'b1, 1'b0);
        check("unlocked_locked", int'(locked), 0);
        check("unlocked_valid", int'(smp.code_valid), 0);
        drive_bit(1'b1, 1'b1);
        check("lock_after_sync", int'(locked), 1);

        // DAC codes 0,7,3 twice each.
        for (int k = 0; k < 6; k++) win(0, dac_highs(t1_dac[k]), 1'b1, 1'b1, t1_exp[k]);
        check("t1_sync_err", int'(sync_err), 0);

        // Backpressure across two windows: code 5 overwritten by code 2.
        drive_bit(1'b1, 1'b0);
        smp.code_ready = 1'b0;
        win(1, dac_highs(5), 1'b1, 1'b0, 0);
        check("t3_code5", int'(smp.code), 5);
        check("t3_no_overrun_yet", int'(overrun), 0);
        win(0, dac_highs(2), 1'b1, 1'b1, 2);
        check("t3_code2", int'(smp.code), 2);
        check("t3_overrun", int'(overrun), 1);
        clr_err = 1'b1;
        drive_bit(1'b0, 1'b0);
        clr_err = 1'b0;
        check("t3_overrun_clr", int'(overrun), 0);
        check("t3_valid_held", int'(smp.code_valid), 1);
        check("t3_code_held", int'(smp.code), 2);
        smp.code_ready = 1'b1;
        drive_bit(1'b0, 1'b0);
        check("t3_valid_drop", int'(smp.code_valid), 0);
        win(2, 0, 1'b1, 1'b1, 0);

        // Early sync at idx 3 discards the window.
        repeat (3) drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        check("t4_sync_err", int'(sync_err), 1);
        check("t4_no_code", int'(smp.code_valid), 0);
        win(0, 1, 1'b1, 1'b1, 0);
        clr_err = 1'b1;
        drive_bit(1'b0, 1'b0);
        clr_err = 1'b0;
        check("t4_sync_err_clr", int'(sync_err), 0);
        win(1, 0, 1'b1, 1'b1, 0);

        // Missing sync with all-high window: saturated code still published.
        win(0, N, 1'b0, 1'b1, 7);
        check("t5_sync_err", int'(sync_err), 1);
        check("t5_locked", int'(locked), 1);
        win(0, dac_highs(3), 1'b1, 1'b1, 3);

        // Reset mid-window with a code pending.
        drive_bit(1'b1, 1'b0);
        smp.code_ready = 1'b0;
        win(1, dac_highs(5), 1'b1, 1'b0, 0);
        check("t6_pending_valid", int'(smp.code_valid), 1);
        check("t6_pending_code", int'(smp.code), 5);
        repeat (5) drive_bit(1'b1, 1'b0);
        rst = 1'b1;
        drive_bit(1'b1, 1'b0);
        rst = 1'b0;
        check("t6_locked", int'(locked), 0);
        check("t6_valid", int'(smp.code_valid), 0);
        check("t6_code", int'(smp.code), 0);
        check("t6_sync_err", int'(sync_err), 0);
        check("t6_overrun", int'(overrun), 0);
        smp.code_ready = 1'b1;
        repeat (3) drive_bit(1'b1, 1'b0);
        check("t6_still_unlocked", int'(locked), 0);
        drive_bit(1'b0, 1'b1);
        check("t6_relock", int'(locked), 1);
        win(0, N, 1'b1, 1'b1, 7);
        drive_bit(1'b0, 1'b0);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
